// File: rtl/i2s_transmit_24.sv
// I2S (Philips) bus-master transmitter: 24-bit stereo samples carried in 64-bit frames.
// A one-entry holding buffer feeds the frame registers once per frame.
module i2s_transmit_24 #(
   parameter int unsigned CLK_DIV_HALF = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic        s_valid_i,
   input  logic [23:0] s_left_i,
   input  logic [23:0] s_right_i,
   output logic        s_ready_o,
   output logic        sck_o,
   output logic        ws_o,
   output logic        sd_o,
   output logic        underrun_o
);
   localparam int unsigned DIV_W = 8;
   localparam int unsigned IDX_W = 6;
   localparam int unsigned SMP_W = 24;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_HALF - 1);
   localparam logic [IDX_W-1:0] IDX_LOAD = IDX_W'(62);

   logic [DIV_W-1:0] r_div;
   logic             r_sck;
   logic [IDX_W-1:0] r_idx;
   logic             r_ws;
   logic             r_sd;
   logic             r_underrun;
   logic             r_ready;
   logic             r_buf_full;
   logic [SMP_W-1:0] r_buf_l;
   logic [SMP_W-1:0] r_buf_r;
   logic [SMP_W-1:0] r_frm_l;
   logic [SMP_W-1:0] r_frm_r;

   logic             w_tc;
   logic             w_fall;
   logic             w_load;
   logic             w_accept;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [SMP_W-1:0] w_frm_l_nxt;
   logic [SMP_W-1:0] w_frm_r_nxt;
   logic             w_ws_nxt;
   logic             w_sd_nxt;

   // Next bit index, frame-register load and the slot bit presented after the falling edge
   always_comb begin
      w_tc        = (r_div == DIV_LAST);
      w_fall      = enable_i && w_tc && r_sck;
      w_load      = w_fall && (r_idx == IDX_LOAD);
      w_accept    = s_valid_i && r_ready;
      w_idx_nxt   = r_idx + IDX_W'(1);
      w_frm_l_nxt = r_frm_l;
      w_frm_r_nxt = r_frm_r;
      if (w_load) begin
         w_frm_l_nxt = r_buf_full ? r_buf_l : '0;
         w_frm_r_nxt = r_buf_full ? r_buf_r : '0;
      end
      w_ws_nxt = (w_idx_nxt >= IDX_W'(31)) && (w_idx_nxt <= IDX_W'(62));
      w_sd_nxt = 1'b0;
      if (w_idx_nxt <= IDX_W'(23)) begin
         w_sd_nxt = w_frm_l_nxt[5'(IDX_W'(23) - w_idx_nxt)];
      end else if ((w_idx_nxt >= IDX_W'(32)) && (w_idx_nxt <= IDX_W'(55))) begin
         w_sd_nxt = w_frm_r_nxt[5'(IDX_W'(55) - w_idx_nxt)];
      end
   end

   // Serial engine: divider, bit clock, bit index, frame registers; disable aborts to idle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_div      <= '0;
         r_sck      <= 1'b0;
         r_idx      <= IDX_LOAD;
         r_ws       <= 1'b0;
         r_sd       <= 1'b0;
         r_underrun <= 1'b0;
         r_frm_l    <= '0;
         r_frm_r    <= '0;
      end else if (!enable_i) begin
         r_div      <= '0;
         r_sck      <= 1'b0;
         r_idx      <= IDX_LOAD;
         r_ws       <= 1'b0;
         r_sd       <= 1'b0;
         r_underrun <= 1'b0;
         r_frm_l    <= '0;
         r_frm_r    <= '0;
      end else begin
         r_underrun <= w_load && !r_buf_full;
         if (w_tc) begin
            r_div <= '0;
            r_sck <= ~r_sck;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
         if (w_fall) begin
            r_idx <= w_idx_nxt;
            r_ws  <= w_ws_nxt;
            r_sd  <= w_sd_nxt;
         end
         r_frm_l <= w_frm_l_nxt;
         r_frm_r <= w_frm_r_nxt;
      end
   end

   // Holding buffer keeps running while disabled; ready is kept as its own flop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_buf_full <= 1'b0;
         r_ready    <= 1'b1;
         r_buf_l    <= '0;
         r_buf_r    <= '0;
      end else if (w_accept) begin
         r_buf_full <= 1'b1;
         r_ready    <= 1'b0;
         r_buf_l    <= s_left_i;
         r_buf_r    <= s_right_i;
      end else if (w_load && r_buf_full) begin
         r_buf_full <= 1'b0;
         r_ready    <= 1'b1;
      end
   end

   assign s_ready_o  = r_ready;
   assign sck_o      = r_sck;
   assign ws_o       = r_ws;
   assign sd_o       = r_sd;
   assign underrun_o = r_underrun;
endmodule

// File: tb/tb_i2s_transmit_24.sv
// Bench for i2s_transmit_24: two instances (half-periods 4 and 1) checked every cycle against
// a cycle-count based model, plus a serial receiver that reassembles words on SCK rises.
module tb_i2s_transmit_24;
   localparam int ND = 2;
   localparam int unsigned N0 = 4;
   localparam int unsigned N1 = 1;
   localparam int RXN = 8192;

   logic clk = 1'b0;
   logic rst_n;
   logic enable;
   logic s_valid;
   logic [23:0] s_left;
   logic [23:0] s_right;
   logic [ND-1:0] rdy, sck, ws, sd, und;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   i2s_transmit_24 #(.CLK_DIV_HALF(N0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .s_valid_i(s_valid),
      .s_left_i(s_left), .s_right_i(s_right), .s_ready_o(rdy[0]), .sck_o(sck[0]),
      .ws_o(ws[0]), .sd_o(sd[0]), .underrun_o(und[0]));

   i2s_transmit_24 #(.CLK_DIV_HALF(N1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .s_valid_i(s_valid),
      .s_left_i(s_left), .s_right_i(s_right), .s_ready_o(rdy[1]), .sck_o(sck[1]),
      .ws_o(ws[1]), .sd_o(sd[1]), .underrun_o(und[1]));

   function automatic int unsigned nh(int d);
      return (d == 0) ? N0 : N1;
   endfunction

   // Model state: enabled clock count, buffer, frame pair, underrun of the last edge
   int unsigned m_cnt [ND];
   logic        m_full [ND];
   logic [23:0] m_bl [ND], m_br [ND], m_fl [ND], m_fr [ND];
   logic        m_und [ND];
   logic        m_acc, m_load;

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < ND; d++) begin
         if (!rst_n) begin
            m_cnt[d] = 0; m_full[d] = 1'b0; m_und[d] = 1'b0;
            m_bl[d] = '0; m_br[d] = '0; m_fl[d] = '0; m_fr[d] = '0;
         end else begin
            m_acc  = s_valid && !m_full[d];
            m_load = 1'b0;
            if (enable) begin
               m_cnt[d] = m_cnt[d] + 1;
               m_load = ((m_cnt[d] % (2 * nh(d))) == 0) && (((m_cnt[d] / (2 * nh(d))) % 64) == 1);
            end else begin
               m_cnt[d] = 0; m_fl[d] = '0; m_fr[d] = '0;
            end
            m_und[d] = m_load && !m_full[d];
            if (m_load) begin
               m_fl[d] = m_full[d] ? m_bl[d] : '0;
               m_fr[d] = m_full[d] ? m_br[d] : '0;
               m_full[d] = 1'b0;
            end
            if (m_acc) begin
               m_bl[d] = s_left; m_br[d] = s_right; m_full[d] = 1'b1;
            end
         end
      end
   end

   // Expected {sck, ws, sd, ready} from the number of enabled clocks seen
   function automatic logic [3:0] expect_out(int unsigned cnt, int unsigned n, logic [23:0] fl,
                                             logic [23:0] fr, logic full);
      int unsigned f = cnt / (2 * n);
      int unsigned idx = (62 + f) % 64;
      logic s = ((cnt / n) % 2) == 1;
      logic w = 1'b0;
      logic b = 1'b0;
      if (f > 0) begin
         w = (idx >= 31) && (idx <= 62);
         if (idx <= 23) b = fl[5'(23 - idx)];
         else if (idx >= 32 && idx <= 55) b = fr[5'(55 - idx)];
      end
      return {s, w, b, !full};
   endfunction

   // Receiver on instance 0: sample SD on every SCK rise
   logic rx_bits [RXN];
   time  rx_time [RXN];
   int   rx_n = 0;
   always @(posedge sck[0]) begin
      if (rx_n < RXN) begin
         rx_bits[rx_n] = sd[0];
         rx_time[rx_n] = $time;
         rx_n = rx_n + 1;
      end
   end

   // Rise number k after enable carries idx (62+k)%64; frame 1 left MSB is rise base+2
   function automatic logic [23:0] rx_word(int base, int frame, bit right);
      logic [23:0] w;
      int k0 = base + 2 + 64 * (frame - 1) + (right ? 32 : 0);
      for (int b = 0; b < 24; b++) w[23 - b] = rx_bits[k0 + b];
      return w;
   endfunction

   logic [4:0] exp_o, got_o;

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         checks++;
         if ({sck[d], ws[d], sd[d], rdy[d], und[d]} !== 5'b00010) begin
            failures++;
            $display("FAIL reset dut%0d got %b exp 00010", d, {sck[d], ws[d], sd[d], rdy[d], und[d]});
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         checks++;
         if ({sck[d], ws[d], sd[d], rdy[d], und[d]} !== 5'b00010) begin
            failures++;
            $display("FAIL reset_idle dut%0d got %b exp 00010", d, {sck[d], ws[d], sd[d], rdy[d], und[d]});
         end
      end
   endtask

   task automatic test_known_pair();
      int base, und_cnt;
      logic pad;
      s_valid = 1'b1; s_left = 24'h800001; s_right = 24'h7FFFFE;
      @(negedge clk);
      s_valid = 1'b0;
      checks++;
      if (rdy[0] !== 1'b0) begin
         failures++; $display("FAIL known_ready_while_idle got %b exp 0", rdy[0]);
      end
      base = rx_n; und_cnt = 0; enable = 1'b1;
      repeat (519) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            exp_o = {expect_out(m_cnt[d], nh(d), m_fl[d], m_fr[d], m_full[d]), m_und[d]};
            got_o = {sck[d], ws[d], sd[d], rdy[d], und[d]};
            checks++;
            if (got_o !== exp_o) begin
               failures++;
               $display("FAIL known_cycle dut%0d @%0t sck/ws/sd/rdy/und got %b exp %b", d, $time, got_o, exp_o);
            end
         end
         if (und[0]) und_cnt++;
      end
      checks++;
      if (rx_n - base != 65) begin
         failures++; $display("FAIL known_rise_count got %0d exp 65", rx_n - base);
      end
      checks++;
      if (rx_time[base + 64] - rx_time[base] != 64 * 80) begin
         failures++; $display("FAIL known_sck_period got %0t exp %0d", rx_time[base + 64] - rx_time[base], 64 * 80);
      end
      checks++;
      if (rx_word(base, 1, 1'b0) !== 24'h800001) begin
         failures++; $display("FAIL known_left got %h exp 800001", rx_word(base, 1, 1'b0));
      end
      checks++;
      if (rx_word(base, 1, 1'b1) !== 24'h7FFFFE) begin
         failures++; $display("FAIL known_right got %h exp 7ffffe", rx_word(base, 1, 1'b1));
      end
      pad = 1'b0;
      for (int i = 24; i <= 31; i++) pad = pad | rx_bits[base + 2 + i];
      for (int i = 56; i <= 61; i++) pad = pad | rx_bits[base + 2 + i];
      checks++;
      if (pad !== 1'b0) begin
         failures++; $display("FAIL known_pad_bits got %b exp 0", pad);
      end
      checks++;
      if (und_cnt != 0) begin
         failures++; $display("FAIL known_no_underrun got %0d exp 0", und_cnt);
      end
   endtask

   task automatic test_underrun();
      int und_cnt = 0, ones = 0, ws_rise = 0;
      logic ws_prev = ws[0];
      repeat (1024) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            exp_o = {expect_out(m_cnt[d], nh(d), m_fl[d], m_fr[d], m_full[d]), m_und[d]};
            got_o = {sck[d], ws[d], sd[d], rdy[d], und[d]};
            checks++;
            if (got_o !== exp_o) begin
               failures++;
               $display("FAIL underrun_cycle dut%0d @%0t sck/ws/sd/rdy/und got %b exp %b", d, $time, got_o, exp_o);
            end
         end
         if (und[0]) und_cnt++;
         if (sd[0]) ones++;
         if (ws[0] && !ws_prev) ws_rise++;
         ws_prev = ws[0];
      end
      checks++;
      if (und_cnt != 2) begin
         failures++; $display("FAIL underrun_pulses got %0d exp 2", und_cnt);
      end
      checks++;
      if (ones != 0) begin
         failures++; $display("FAIL underrun_sd_ones got %0d exp 0", ones);
      end
      checks++;
      if (ws_rise != 2) begin
         failures++; $display("FAIL underrun_ws_rises got %0d exp 2", ws_rise);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] p1l = 24'($urandom), p1r = 24'($urandom), p2l = 24'($urandom), p2r = 24'($urandom);
      int base, stage = 0, c1 = 0, c2 = 0;
      logic will;
      @(negedge clk); enable = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      base = rx_n; enable = 1'b1; s_valid = 1'b1; s_left = p1l; s_right = p1r;
      for (int c = 1; c <= 1000; c++) begin
         will = s_valid && rdy[0];
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            exp_o = {expect_out(m_cnt[d], nh(d), m_fl[d], m_fr[d], m_full[d]), m_und[d]};
            got_o = {sck[d], ws[d], sd[d], rdy[d], und[d]};
            checks++;
            if (got_o !== exp_o) begin
               failures++;
               $display("FAIL b2b_cycle dut%0d @%0t sck/ws/sd/rdy/und got %b exp %b", d, $time, got_o, exp_o);
            end
         end
         if (will) begin
            if (stage == 0) begin
               stage = 1; c1 = c; s_left = p2l; s_right = p2r;
            end else if (stage == 1) begin
               stage = 2; c2 = c; s_valid = 1'b0;
            end
         end
         if (stage == 1 && c == c1 + 1) begin
            checks++;
            if (rdy[0] !== 1'b0) begin
               failures++; $display("FAIL b2b_ready_low got %b exp 0", rdy[0]);
            end
         end
      end
      s_valid = 1'b0;
      checks++;
      if (stage != 2 || c2 - c1 != 8) begin
         failures++; $display("FAIL b2b_accept_gap got stage=%0d gap=%0d exp stage=2 gap=8", stage, c2 - c1);
      end
      checks++;
      if ({rx_word(base, 1, 1'b0), rx_word(base, 1, 1'b1)} !== {p1l, p1r}) begin
         failures++; $display("FAIL b2b_frame1 got %h_%h exp %h_%h", rx_word(base, 1, 1'b0), rx_word(base, 1, 1'b1), p1l, p1r);
      end
      checks++;
      if ({rx_word(base, 2, 1'b0), rx_word(base, 2, 1'b1)} !== {p2l, p2r}) begin
         failures++; $display("FAIL b2b_frame2 got %h_%h exp %h_%h", rx_word(base, 2, 1'b0), rx_word(base, 2, 1'b1), p2l, p2r);
      end
   endtask

   task automatic test_load_cycle_push();
      logic [23:0] pl = 24'($urandom), pr = 24'($urandom);
      int base;
      @(negedge clk); enable = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      base = rx_n; enable = 1'b1;
      for (int c = 1; c <= 1000; c++) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            exp_o = {expect_out(m_cnt[d], nh(d), m_fl[d], m_fr[d], m_full[d]), m_und[d]};
            got_o = {sck[d], ws[d], sd[d], rdy[d], und[d]};
            checks++;
            if (got_o !== exp_o) begin
               failures++;
               $display("FAIL loadpush_cycle dut%0d @%0t sck/ws/sd/rdy/und got %b exp %b", d, $time, got_o, exp_o);
            end
         end
         if (c == 7) begin
            s_valid = 1'b1; s_left = pl; s_right = pr;
         end else if (c == 8) begin
            s_valid = 1'b0;
            checks++;
            if ({und[0], rdy[0]} !== 2'b10) begin
               failures++; $display("FAIL loadpush_underrun und/rdy got %b exp 10", {und[0], rdy[0]});
            end
         end
      end
      checks++;
      if ({rx_word(base, 1, 1'b0), rx_word(base, 1, 1'b1)} !== 48'h0) begin
         failures++; $display("FAIL loadpush_frame1 got %h_%h exp 000000_000000", rx_word(base, 1, 1'b0), rx_word(base, 1, 1'b1));
      end
      checks++;
      if ({rx_word(base, 2, 1'b0), rx_word(base, 2, 1'b1)} !== {pl, pr}) begin
         failures++; $display("FAIL loadpush_frame2 got %h_%h exp %h_%h", rx_word(base, 2, 1'b0), rx_word(base, 2, 1'b1), pl, pr);
      end
   endtask

   task automatic test_enable_drop();
      logic [23:0] ql = 24'($urandom), qr = 24'($urandom);
      int base;
      time tn;
      @(negedge clk); enable = 1'b0; s_valid = 1'b1; s_left = 24'($urandom); s_right = 24'($urandom);
      @(negedge clk); s_valid = 1'b0; enable = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            exp_o = {expect_out(m_cnt[d], nh(d), m_fl[d], m_fr[d], m_full[d]), m_und[d]};
            got_o = {sck[d], ws[d], sd[d], rdy[d], und[d]};
            checks++;
            if (got_o !== exp_o) begin
               failures++;
               $display("FAIL drop_cycle dut%0d @%0t sck/ws/sd/rdy/und got %b exp %b", d, $time, got_o, exp_o);
            end
         end
      end
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if ({sck[0], ws[0], sd[0]} !== 3'b000) begin
         failures++; $display("FAIL drop_idle sck/ws/sd got %b exp 000", {sck[0], ws[0], sd[0]});
      end
      s_valid = 1'b1; s_left = ql; s_right = qr;
      @(negedge clk);
      s_valid = 1'b0; base = rx_n; tn = $time; enable = 1'b1;
      repeat (600) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            exp_o = {expect_out(m_cnt[d], nh(d), m_fl[d], m_fr[d], m_full[d]), m_und[d]};
            got_o = {sck[d], ws[d], sd[d], rdy[d], und[d]};
            checks++;
            if (got_o !== exp_o) begin
               failures++;
               $display("FAIL reenable_cycle dut%0d @%0t sck/ws/sd/rdy/und got %b exp %b", d, $time, got_o, exp_o);
            end
         end
      end
      checks++;
      if (rx_time[base] != tn + 5 + (N0 - 1) * 10) begin
         failures++; $display("FAIL reenable_first_rise got %0t exp %0t", rx_time[base], tn + 5 + (N0 - 1) * 10);
      end
      checks++;
      if ({rx_word(base, 1, 1'b0), rx_word(base, 1, 1'b1)} !== {ql, qr}) begin
         failures++; $display("FAIL reenable_frame got %h_%h exp %h_%h", rx_word(base, 1, 1'b0), rx_word(base, 1, 1'b1), ql, qr);
      end
   endtask

   task automatic test_async_reset();
      int und_cnt [ND];
      @(negedge clk); enable = 1'b0; s_valid = 1'b1; s_left = 24'($urandom); s_right = 24'($urandom);
      @(negedge clk); enable = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         s_valid = 1'b0;
         for (int d = 0; d < ND; d++) begin
            exp_o = {expect_out(m_cnt[d], nh(d), m_fl[d], m_fr[d], m_full[d]), m_und[d]};
            got_o = {sck[d], ws[d], sd[d], rdy[d], und[d]};
            checks++;
            if (got_o !== exp_o) begin
               failures++;
               $display("FAIL areset_pre dut%0d @%0t sck/ws/sd/rdy/und got %b exp %b", d, $time, got_o, exp_o);
            end
         end
      end
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < ND; d++) begin
         checks++;
         if ({sck[d], ws[d], sd[d], rdy[d], und[d]} !== 5'b00010) begin
            failures++;
            $display("FAIL areset_async dut%0d got %b exp 00010", d, {sck[d], ws[d], sd[d], rdy[d], und[d]});
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      und_cnt[0] = 0; und_cnt[1] = 0;
      repeat (300) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            exp_o = {expect_out(m_cnt[d], nh(d), m_fl[d], m_fr[d], m_full[d]), m_und[d]};
            got_o = {sck[d], ws[d], sd[d], rdy[d], und[d]};
            checks++;
            if (got_o !== exp_o) begin
               failures++;
               $display("FAIL areset_post dut%0d @%0t sck/ws/sd/rdy/und got %b exp %b", d, $time, got_o, exp_o);
            end
            if (und[d]) und_cnt[d]++;
         end
      end
      checks++;
      if (und_cnt[0] != 1 || und_cnt[1] != 3) begin
         failures++; $display("FAIL areset_underruns got %0d/%0d exp 1/3", und_cnt[0], und_cnt[1]);
      end
   endtask

   task automatic test_random();
      repeat (3000) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            exp_o = {expect_out(m_cnt[d], nh(d), m_fl[d], m_fr[d], m_full[d]), m_und[d]};
            got_o = {sck[d], ws[d], sd[d], rdy[d], und[d]};
            checks++;
            if (got_o !== exp_o) begin
               failures++;
               $display("FAIL random_cycle dut%0d @%0t sck/ws/sd/rdy/und got %b exp %b", d, $time, got_o, exp_o);
            end
         end
         s_valid = ($urandom % 4) == 0;
         s_left  = 24'($urandom);
         s_right = 24'($urandom);
         if (enable) enable = ($urandom % 500) != 0;
         else        enable = ($urandom % 8) == 0;
      end
      enable = 1'b0; s_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_known_pair();
      test_underrun();
      test_back_to_back();
      test_load_cycle_push();
      test_enable_drop();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/i2s_transmit_24.md
I2S_TRANSMIT_24 -- requirements
Module: i2s_transmit_24

Interface
REQ-001 The block SHALL have parameter CLK_DIV_HALF, default 4, giving clk_i cycles per SCK half-period (legal range 1..255).
REQ-002 clk_i  input  1  single system clock; all logic rising-edge clocked.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 enable_i  input  1  1 = run the serial clock and frames, 0 = idle.
REQ-005 s_valid_i  input  1  sample-pair offered.
REQ-006 s_left_i  input  24  signed left sample, two's complement.
REQ-007 s_right_i  input  24  signed right sample, two's complement.
REQ-008 s_ready_o  output  1  holding buffer can accept a pair.
REQ-009 sck_o  output  1  I2S bit clock (block is bus master).
REQ-010 ws_o  output  1  I2S word select, 0 = left slot, 1 = right slot.
REQ-011 sd_o  output  1  I2S serial data, MSB first.
REQ-012 underrun_o  output  1  one-cycle pulse when a frame starts with no buffered pair.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 Divider: counter 0..CLK_DIV_HALF-1; on terminal count, counter wraps to 0 and sck_o toggles; one SCK period = 2*CLK_DIV_HALF clk_i cycles.
REQ-015 Frame = 64 SCK periods; bit index idx (0..63) advances, wrapping 63->0, in the same cycle sck_o goes 1->0 (falling edge).
REQ-016 ws_o and sd_o SHALL change only in the cycle sck_o falls, so the receiver samples them stably on the next SCK rise.
REQ-017 ws_o SHALL be 1 for idx 31..62 and 0 for idx 63 and 0..30 (WS leads MSB by one bit, Philips I2S).
REQ-018 sd_o SHALL carry left bit 23-idx for idx 0..23, right bit 55-idx for idx 32..55, and 0 for idx 24..31 and 56..63.
REQ-019 One-entry holding buffer: s_ready_o = !buf_full; accept when s_valid_i && s_ready_o, capturing s_left_i/s_right_i and setting buf_full next cycle.
REQ-020 Frame load occurs in the cycle idx advances 62->63: if buf_full, buffer moves to the frame registers and buf_full clears; otherwise the frame registers load 0 and underrun_o pulses for exactly that cycle.
REQ-021 Frame registers SHALL NOT change between loads; the pair in flight is fixed for idx 63..62 of the next wrap.
REQ-022 Accept and load in the same cycle with buffer empty: the accepted pair goes to the buffer (no bypass), the load is an underrun, and that pair plays in the following frame.
REQ-023 Load clearing buf_full and s_ready_o rising is visible the cycle after the load; a new accept is possible from that cycle.
REQ-024 enable_i = 0 SHALL force sck_o=0, ws_o=0, sd_o=0, divider=0, idx=62, frame registers=0, no underrun_o; the buffer still accepts.
REQ-025 On enable_i 0->1, the first SCK rise occurs CLK_DIV_HALF cycles later and the first falling edge performs the REQ-020 load (idx 62->63).
REQ-026 Deasserting enable_i mid-frame SHALL abort the frame immediately to the REQ-024 idle state; buffer contents are kept.

Reset
REQ-027 While rst_ni = 0: sck_o=0, ws_o=0, sd_o=0, underrun_o=0, s_ready_o=1, buf_full=0, divider=0, idx=62, frame registers=0.
REQ-028 Reset SHALL take effect asynchronously mid-frame and discard any buffered or in-flight pair; deassertion is synchronous to clk_i.

Verification
REQ-029 CLK_DIV_HALF=4, enable_i=1, push L=24'h800001, R=24'h7FFFFE before first load -> sck_o period 8 cycles, frame 512 cycles; capture via sck rise gives L=800001, R=7FFFFE; sd_o=0 on idx 24..31, 56..63; no underrun.
REQ-030 enable_i=1 with no sample -> underrun_o pulses once per frame at each 62->63 transition; sd_o constantly 0; ws_o 50% with edges at idx 31/63.
REQ-031 Push pairs P1,P2 back-to-back -> P1 accepted, s_ready_o low until P1 loads; P2 accepted the cycle after; P1 then P2 emitted in consecutive frames.
REQ-032 s_valid_i asserted in the exact load cycle with buffer empty -> underrun_o=1 that cycle, pair emitted next frame.
REQ-033 enable_i dropped at idx 10 -> next cycle sck_o=ws_o=sd_o=0; re-enable -> first SCK rise after 4 cycles, clean frame from buffered pair.
REQ-034 rst_ni pulsed low mid-right-slot with CLK_DIV_HALF=1 -> all outputs per REQ-027 without a clk_i edge; s_ready_o=1; next frame underruns unless refilled.
